vga_fb_arbiter: RTL and testbench

//  Shares one single-port sync frame-buffer RAM between VGA display refresh and a pixel writer.

---
 rtl/vga_fb_pkg.sv | 22 ++
 rtl/vga_fb_addr_gen.sv | 23 ++
 rtl/vga_fb_arbiter.sv | 122 ++++++++++++
 tb/tb_vga_fb_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// Shared constants and state type for the VGA frame-buffer arbiter.
// Frame-buffer geometry is derived from the 640x480 display and a log2 downscale.
package vga_fb_pkg;

    localparam int H_DISP       = 640;
    localparam int V_DISP       = 480;
    localparam int SCALE_SH_DEF = 2;
    localparam int FB_W         = H_DISP >> SCALE_SH_DEF;
    localparam int FB_H         = V_DISP >> SCALE_SH_DEF;
    localparam int FB_DEPTH     = FB_W * FB_H;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR
    } state_t;

    function automatic int fb_depth(input int scale_sh);
        return (H_DISP >> scale_sh) * (V_DISP >> scale_sh);
    endfunction

endpackage

// File: rtl/vga_fb_addr_gen.sv
// Maps a display (h_count, v_count) position to a linear downscaled frame-buffer address.
// Purely combinational; both coordinates are pre-shifted before the row multiply.
module vga_fb_addr_gen
    import vga_fb_pkg::*;
#(
    parameter int SCALE_SH = 2,
    parameter int ADDR_W   = 15
) (
    input  logic [9:0]        h_count,
    input  logic [9:0]        v_count,
    output logic [ADDR_W-1:0] addr
);

    localparam int ROW_W = H_DISP >> SCALE_SH;

    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;

    assign row  = ADDR_W'(v_count >> SCALE_SH);
    assign col  = ADDR_W'(h_count >> SCALE_SH);
    assign addr = row * ADDR_W'(ROW_W) + col;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port synchronous frame-buffer RAM between display refresh reads and a pixel writer.
// Define FB_ACTIVE_WRITE_EN to let the writer use non-tick clocks during active video.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int SCALE_SH = 2,
    parameter int RGB_W    = 12,
    parameter int ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_tick,
    input  logic              vd_on,
    input  logic              h_sync,
    input  logic              v_sync,
    input  logic [9:0]        h_count,
    input  logic [9:0]        v_count,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [RGB_W-1:0]  wr_data,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [RGB_W-1:0]  mem_wdata,
    input  logic [RGB_W-1:0]  mem_rdata,
    output logic [RGB_W-1:0]  rgb,
    output logic              rgb_on,
    output logic              hs_out,
    output logic              vs_out
);

    localparam int DEPTH = fb_depth(SCALE_SH);

    logic [ADDR_W-1:0] pix_addr;
    logic              wr_ok;
    logic              wr_in_range;
    state_t            state;
    logic              rd_valid;
    logic [1:0]        vd_d;
    logic [1:0]        hs_d;
    logic [1:0]        vs_d;

    vga_fb_addr_gen #(
        .SCALE_SH(SCALE_SH),
        .ADDR_W  (ADDR_W)
    ) u_addr_gen (
        .h_count(h_count),
        .v_count(v_count),
        .addr   (pix_addr)
    );

`ifdef FB_ACTIVE_WRITE_EN
    assign wr_ok = !(p_tick && vd_on);
`else
    assign wr_ok = !vd_on;
`endif

    // One extra bit so a depth equal to 2**ADDR_W still compares correctly.
    assign wr_in_range = ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));

    // NOTE: registered state and outputs use non-blocking assignments so every
    // block samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ack    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            wr_ack <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (p_tick && vd_on) begin
                state    <= RD;
                mem_en   <= 1'b1;
                mem_addr <= pix_addr;
            end else if (wr_req && wr_ok && state != WR) begin
                // The writer still holds wr_req while it sees the ack, so a
                // grant is never issued back-to-back.
                state     <= WR;
                mem_en    <= 1'b1;
                mem_we    <= wr_in_range;
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
                wr_ack    <= 1'b1;
            end else begin
                state <= IDLE;
            end
        end
    end

    // Video outputs trail the sync inputs by three clocks to meet the RAM read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            vd_d     <= '0;
            hs_d     <= '0;
            vs_d     <= '0;
            rgb_on   <= 1'b0;
            hs_out   <= 1'b0;
            vs_out   <= 1'b0;
            rgb      <= '0;
        end else begin
            rd_valid <= (state == RD);
            vd_d     <= {vd_d[0], vd_on};
            hs_d     <= {hs_d[0], h_sync};
            vs_d     <= {vs_d[0], v_sync};
            rgb_on   <= vd_d[1];
            hs_out   <= hs_d[1];
            vs_out   <= vs_d[1];
            if (!vd_d[1]) begin
                rgb <= '0;
            end else if (rd_valid) begin
                rgb <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: directed literal checks plus randomized video/writer traffic
// compared every cycle against a cycle-indexed behavioural model backed by a shadow frame buffer.
module tb_vga_fb_arbiter;

    localparam int ADDR_W = 15;
    localparam int RGB_W  = 12;
    localparam int DEPTH  = 19200;

    typedef enum {K_IDLE, K_RD, K_WR} kind_t;

    logic              clk     = 1'b0;
    logic              rst     = 1'b1;
    logic              p_tick  = 1'b0;
    logic              vd_on   = 1'b0;
    logic              h_sync  = 1'b0;
    logic              v_sync  = 1'b0;
    logic [9:0]        h_count = '0;
    logic [9:0]        v_count = '0;
    logic              wr_req  = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [RGB_W-1:0]  wr_data = '0;
    logic              wr_ack;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [RGB_W-1:0]  mem_wdata;
    logic [RGB_W-1:0]  mem_rdata = '0;
    logic [RGB_W-1:0]  rgb;
    logic              rgb_on;
    logic              hs_out;
    logic              vs_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .p_tick   (p_tick),
        .vd_on    (vd_on),
        .h_sync   (h_sync),
        .v_sync   (v_sync),
        .h_count  (h_count),
        .v_count  (v_count),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .rgb      (rgb),
        .rgb_on   (rgb_on),
        .hs_out   (hs_out),
        .vs_out   (vs_out)
    );

    // Power-up contents of the frame buffer; address 162 is pinned for a literal check.
    function automatic logic [RGB_W-1:0] init_val(input int a);
        if (a == 162) return 12'h5A3;
        return 12'(a * 29 + 11) ^ 12'h6C1;
    endfunction

    // Downscaled linear address: 160 pixels per stored row, 4x4 display pixels per stored pixel.
    function automatic int pix_ref(input logic [9:0] h, input logic [9:0] v);
        return (int'(v) / 4) * 160 + int'(h) / 4;
    endfunction

    // Bench-side synchronous single-port RAM.
    logic [RGB_W-1:0] ram   [0:32767];
    bit               ram_w [0:32767];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]   <= mem_wdata;
                ram_w[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= ram_w[mem_addr] ? ram[mem_addr] : init_val(int'(mem_addr));
            end
        end
    end

    // ---------------- behavioural model ----------------
    kind_t            m_op = K_IDLE;
    kind_t            m_next;
    int               cyc  = 0;
    bit               h_rst [8];
    bit               h_vd  [8];
    bit               h_hs  [8];
    bit               h_vs  [8];
    bit               h_rd  [8];
    logic [RGB_W-1:0] h_rv  [8];
    logic [RGB_W-1:0] fb_model [0:32767];
    bit               fb_w     [0:32767];

    bit               exp_ack    = 1'b0;
    bit               exp_en     = 1'b0;
    bit               exp_we     = 1'b0;
    logic [ADDR_W-1:0] exp_addr  = '0;
    logic [RGB_W-1:0] exp_wdata  = '0;
    logic [RGB_W-1:0] exp_rgb    = '0;
    bit               exp_rgb_on = 1'b0;
    bit               exp_hs     = 1'b0;
    bit               exp_vs     = 1'b0;

    function automatic logic [RGB_W-1:0] fb_read(input int a);
        return fb_w[a] ? fb_model[a] : init_val(a);
    endfunction

    always_comb begin
        m_next = K_IDLE;
        if (rst)
            m_next = K_IDLE;
        else if (p_tick && vd_on)
            m_next = K_RD;
`ifdef FB_ACTIVE_WRITE_EN
        else if (wr_req && !(p_tick && vd_on) && m_op != K_WR)
`else
        else if (wr_req && !vd_on && m_op != K_WR)
`endif
            m_next = K_WR;
    end

    always @(posedge clk) begin
        cyc               <= cyc + 1;
        m_op              <= m_next;
        h_rst[cyc[2:0]]   <= rst;
        h_vd[cyc[2:0]]    <= rst ? 1'b0 : vd_on;
        h_hs[cyc[2:0]]    <= rst ? 1'b0 : h_sync;
        h_vs[cyc[2:0]]    <= rst ? 1'b0 : v_sync;
        h_rd[cyc[2:0]]    <= (m_next == K_RD);
        h_rv[cyc[2:0]]    <= fb_read(pix_ref(h_count, v_count));
        if (rst) begin
            exp_ack   <= 1'b0;
            exp_en    <= 1'b0;
            exp_we    <= 1'b0;
            exp_addr  <= '0;
            exp_wdata <= '0;
        end else begin
            exp_ack <= (m_next == K_WR);
            exp_en  <= (m_next != K_IDLE);
            exp_we  <= (m_next == K_WR) && (int'(wr_addr) < DEPTH);
            if (m_next == K_RD) exp_addr <= ADDR_W'(pix_ref(h_count, v_count));
            if (m_next == K_WR) begin
                exp_addr  <= wr_addr;
                exp_wdata <= wr_data;
            end
        end
        if (m_next == K_WR && int'(wr_addr) < DEPTH) begin
            fb_model[wr_addr] <= wr_data;
            fb_w[wr_addr]     <= 1'b1;
        end
        // Video outputs reflect the inputs sampled two edges earlier unless a reset intervened.
        if (rst || h_rst[3'(cyc - 1)] || h_rst[3'(cyc - 2)]) begin
            exp_rgb_on <= 1'b0;
            exp_hs     <= 1'b0;
            exp_vs     <= 1'b0;
            exp_rgb    <= '0;
        end else begin
            exp_rgb_on <= h_vd[3'(cyc - 2)];
            exp_hs     <= h_hs[3'(cyc - 2)];
            exp_vs     <= h_vs[3'(cyc - 2)];
            if (!h_vd[3'(cyc - 2)])
                exp_rgb <= '0;
            else if (h_rd[3'(cyc - 2)])
                exp_rgb <= h_rv[3'(cyc - 2)];
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                check("mon_wr_ack",    32'(wr_ack),    32'(exp_ack));
                check("mon_mem_en",    32'(mem_en),    32'(exp_en));
                check("mon_mem_we",    32'(mem_we),    32'(exp_we));
                check("mon_mem_addr",  32'(mem_addr),  32'(exp_addr));
                check("mon_mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
                check("mon_rgb",       32'(rgb),       32'(exp_rgb));
                check("mon_rgb_on",    32'(rgb_on),    32'(exp_rgb_on));
                check("mon_hs_out",    32'(hs_out),    32'(exp_hs));
                check("mon_vs_out",    32'(vs_out),    32'(exp_vs));
            end
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic writer_step();
        if (wr_req && wr_ack) begin
            wr_req = 1'b0;
        end else if (!wr_req && $urandom_range(0, 3) == 0) begin
            wr_req  = 1'b1;
            if ($urandom_range(0, 15) == 0)
                wr_addr = ADDR_W'($urandom_range(DEPTH, 32767));
            else if ($urandom_range(0, 1) == 0)
                wr_addr = ADDR_W'($urandom_range(0, 639));
            else
                wr_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            wr_data = RGB_W'($urandom);
        end
    endtask

    initial begin
        int  acks;
        bit  tick_hit;
        int  npix;
        int  seg;
        int  pp;
        bit  act;

        fork
            monitor();
        join_none

        // Reset held five clocks mid-frame with a pending write request.
        rst     = 1'b1;
        vd_on   = 1'b1;
        h_count = 10'd100;
        v_count = 10'd50;
        wr_req  = 1'b1;
        wr_addr = 15'd5;
        wr_data = 12'h111;
        for (int i = 0; i < 5; i++) begin
            p_tick = (i % 2 == 0);
            step();
            check("lit_rst_ack", 32'(wr_ack), 32'd0);
            check("lit_rst_rgb_on", 32'(rgb_on), 32'd0);
        end
        check("lit_rst_rgb", 32'(rgb), 32'd0);
        rst    = 1'b0;
        vd_on  = 1'b0;
        p_tick = 1'b0;
        step();
        check("lit_ack_after_rst", 32'(wr_ack), 32'd1);
        check("lit_ack_after_rst_addr", 32'(mem_addr), 32'd5);
        wr_req = 1'b0;
        step();

        // Active video read at h=8, v=4 lands on address 162.
        vd_on   = 1'b1;
        h_count = 10'd8;
        v_count = 10'd4;
        p_tick  = 1'b1;
        step();
        p_tick = 1'b0;
        check("lit_rd_addr", 32'(mem_addr), 32'd162);
        check("lit_rd_en", 32'(mem_en), 32'd1);
        check("lit_rd_we", 32'(mem_we), 32'd0);
        step();
        step();
        check("lit_rd_rgb", 32'(rgb), 32'h5A3);
        check("lit_rd_rgb_on", 32'(rgb_on), 32'd1);
        vd_on = 1'b0;
        step();

        // Blanking write held until acknowledged: exactly one grant.
        wr_req  = 1'b1;
        wr_addr = 15'd100;
        wr_data = 12'hABC;
        acks    = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (wr_ack) begin
                acks++;
                wr_req = 1'b0;
            end
        end
        check("lit_wr_single_ack", 32'(acks), 32'd1);
        check("lit_wr_ram100", 32'(ram[100]), 32'hABC);

        // Write request during active video.
        wr_req   = 1'b1;
        wr_addr  = 15'd200;
        wr_data  = 12'h3C5;
        vd_on    = 1'b1;
        h_count  = 10'd40;
        v_count  = 10'd40;
        acks     = 0;
        tick_hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            p_tick = (i % 4 == 0);
            step();
            if (wr_ack) begin
                acks++;
                if (p_tick) tick_hit = 1'b1;
                wr_req = 1'b0;
            end
        end
        p_tick = 1'b0;
`ifdef FB_ACTIVE_WRITE_EN
        check("lit_active_ack", 32'(acks), 32'd1);
        check("lit_active_ack_off_tick", 32'(tick_hit), 32'd0);
        vd_on = 1'b0;
        step();
`else
        check("lit_active_no_ack", 32'(acks), 32'd0);
        vd_on = 1'b0;
        step();
        check("lit_blank_first_ack", 32'(wr_ack), 32'd1);
        wr_req = 1'b0;
`endif
        step();

        // Out-of-range write is acknowledged but leaves the RAM untouched.
        wr_req  = 1'b1;
        wr_addr = 15'(DEPTH);
        wr_data = 12'hFFF;
        step();
        check("lit_oor_ack", 32'(wr_ack), 32'd1);
        check("lit_oor_we", 32'(mem_we), 32'd0);
        check("lit_oor_en", 32'(mem_en), 32'd1);
        wr_req = 1'b0;
        step();

        // Randomized video timing with a concurrent writer and one mid-run reset.
        npix = 0;
        while (npix < 2400) begin
            act = ($urandom_range(0, 2) != 0);
            seg = act ? int'($urandom_range(8, 40)) : int'($urandom_range(4, 20));
            for (int i = 0; i < seg; i++) begin
                if (npix == 1200) begin
                    rst    = 1'b1;
                    p_tick = 1'b0;
                    repeat (3) begin
                        step();
                        writer_step();
                    end
                    rst = 1'b0;
                end
                vd_on = act;
                if (act && $urandom_range(0, 1) == 0) begin
                    h_count = 10'($urandom_range(0, 63));
                    v_count = 10'($urandom_range(0, 15));
                end else if (act) begin
                    h_count = 10'($urandom_range(0, 639));
                    v_count = 10'($urandom_range(0, 479));
                end else begin
                    h_count = 10'($urandom_range(640, 799));
                    v_count = 10'($urandom_range(0, 524));
                end
                h_sync = 1'($urandom);
                v_sync = 1'($urandom);
                pp     = int'($urandom_range(2, 4));
                for (int c = 0; c < pp; c++) begin
                    p_tick = (c == 0);
                    step();
                    writer_step();
                end
                npix++;
            end
        end

        p_tick = 1'b0;
        vd_on  = 1'b0;
        wr_req = 1'b0;
        repeat (5) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
